// File: rtl/mem_store_queue_pkg.sv
// Shared memory-access mark codes and store-queue entry layout, used by the
// store queue, the load extender and the control decoder.
package mem_store_queue_pkg;

    localparam logic [5:0] MARK_SB = 6'd1;
    localparam logic [5:0] MARK_SH = 6'd2;
    localparam logic [5:0] MARK_SW = 6'd3;
    localparam logic [5:0] MARK_LB = 6'd4;
    localparam logic [5:0] MARK_LH = 6'd5;
    localparam logic [5:0] MARK_LW = 6'd6;

    localparam int WADDR_W = 30;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic [BE_W-1:0]    byteen;
        logic [PC_W-1:0]    pc;
    } sq_entry_t;

endpackage

// File: rtl/mem_store_queue_lane_fmt.sv
// Combinational store formatter: replicates store data across byte lanes,
// derives byte enables and flags misaligned halfword/word stores.
module store_lane_fmt
    import mem_store_queue_pkg::*;
(
    input  logic [5:0]        mark,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] data,
    output logic              is_store,
    output logic [BE_W-1:0]   byteen,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign
);

    always_comb begin
        is_store = 1'b0;
        byteen   = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (mark)
            MARK_SB: begin
                is_store = 1'b1;
                byteen   = 4'b0001 << addr_lo;
                wdata    = {4{data[7:0]}};
            end
            MARK_SH: begin
                is_store = 1'b1;
                byteen   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{data[15:0]}};
                misalign = addr_lo[0];
            end
            MARK_SW: begin
                is_store = 1'b1;
                byteen   = 4'b1111;
                wdata    = data;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_store_queue.sv
// Store queue between the M stage and the data-memory port: formats sb/sh/sw,
// buffers them in a FIFO, drains over req/gnt and flags loads hitting a queued store.
module mem_store_queue
    import mem_store_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [5:0]  st_mark,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_misalign,
    output logic        m_data_req,
    input  logic        m_data_gnt,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        q_empty
);

    // Handshakes: a store transfers on the rising edge where st_valid & st_ready
    // (st_ready = !full, independent of a same-cycle pop); a memory write transfers
    // on the edge where m_data_req & m_data_gnt, and the head holds until then.

    sq_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               misalign_q;

    logic               fmt_is_store;
    logic [BE_W-1:0]    fmt_byteen;
    logic [DATA_W-1:0]  fmt_wdata;
    logic               fmt_misalign;

    logic               full;
    logic               offer;
    logic               push;
    logic               pop;
    logic               hit;
    sq_entry_t          head;
    logic               unused_ld_lo;

    store_lane_fmt u_fmt (
        .mark     (st_mark),
        .addr_lo  (st_addr[1:0]),
        .data     (st_data),
        .is_store (fmt_is_store),
        .byteen   (fmt_byteen),
        .wdata    (fmt_wdata),
        .misalign (fmt_misalign)
    );

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign q_empty  = (count == '0);
    assign st_ready = ~full;
    assign offer    = st_valid & st_ready & fmt_is_store;
    assign push     = offer & ~fmt_misalign;
    assign pop      = m_data_req & m_data_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid      <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= offer & fmt_misalign;
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: valid/count gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{waddr:  st_addr[31:2],
                                  wdata:  fmt_wdata,
                                  byteen: fmt_byteen,
                                  pc:     st_pc};
        end
    end

    assign head          = entries[rd_ptr];
    assign m_data_req    = ~q_empty;
    assign m_data_addr   = q_empty ? 32'd0 : {head.waddr, 2'b00};
    assign m_data_wdata  = q_empty ? 32'd0 : head.wdata;
    assign m_data_byteen = q_empty ? 4'd0  : head.byteen;
    assign m_inst_addr   = q_empty ? 32'd0 : head.pc;
    assign st_misalign   = misalign_q;

    // Word-granular match; a store being accepted this cycle is not yet valid.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].waddr == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_hazard    = ld_check & hit;
    assign unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_mem_store_queue.sv
// Directed bench for mem_store_queue: formatting, misalign pulse, full/hold-off,
// load hazard, push+pop wrap and reset discard, with an in-order write scoreboard.
module tb_mem_store_queue;
    import mem_store_queue_pkg::*;

    localparam int EXP_W = 100;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  st_mark;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_misalign;
    logic        m_data_req;
    logic        m_data_gnt;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        q_empty;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    mem_store_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_mark       (st_mark),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_pc         (st_pc),
        .st_misalign   (st_misalign),
        .m_data_req    (m_data_req),
        .m_data_gnt    (m_data_gnt),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .ld_check      (ld_check),
        .ld_addr       (ld_addr),
        .ld_hazard     (ld_hazard),
        .q_empty       (q_empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // driver tasks
    task automatic offer(input logic [5:0] mark, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] pc);
        st_valid = 1'b1;
        st_mark  = mark;
        st_addr  = addr;
        st_data  = data;
        st_pc    = pc;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_mark  = 6'd0;
        #1;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] byteen, input logic [31:0] pc);
        exp_q.push_back({addr, wdata, byteen, pc});
    endtask

    task automatic wait_empty(input int max_cyc);
        int n;
        n = 0;
        while (!q_empty && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_done", {31'd0, q_empty}, 32'd1);
    endtask

    // scoreboard: every granted write must match the next expected store
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!reset && m_data_req && m_data_gnt) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", m_data_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr",   m_data_addr,            e[99:68]);
                check("wr_wdata",  m_data_wdata,           e[67:36]);
                check("wr_byteen", {28'd0, m_data_byteen}, {28'd0, e[35:32]});
                check("wr_pc",     m_inst_addr,            e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_mark = 6'd0; st_addr = '0; st_data = '0;
        st_pc = '0; m_data_gnt = 1'b0; ld_check = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_q_empty",  {31'd0, q_empty},     32'd1);
        check("rst_st_ready", {31'd0, st_ready},    32'd1);
        check("rst_req",      {31'd0, m_data_req},  32'd0);
        check("rst_misalign", {31'd0, st_misalign}, 32'd0);
        check("rst_addr",     m_data_addr,          32'd0);

        // 1: sb to lane 3, granted immediately
        m_data_gnt = 1'b1;
        expect_write(32'h0000_3000, 32'h7878_7878, 4'b1000, 32'h0000_0100);
        offer(MARK_SB, 32'h0000_3003, 32'h1234_5678, 32'h0000_0100);
        check("t1_req",    {31'd0, m_data_req},    32'd1);
        check("t1_addr",   m_data_addr,            32'h0000_3000);
        check("t1_byteen", {28'd0, m_data_byteen}, 32'h8);
        check("t1_wdata",  m_data_wdata,           32'h7878_7878);
        check("t1_pc",     m_inst_addr,            32'h0000_0100);
        @(posedge clk);
        #2;
        check("t1_empty_after", {31'd0, q_empty},    32'd1);
        check("t1_req_after",   {31'd0, m_data_req}, 32'd0);

        // 2: sh upper half, then misaligned sh / no-op mark / misaligned sw
        m_data_gnt = 1'b0;
        expect_write(32'h0000_1004, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0104);
        offer(MARK_SH, 32'h0000_1006, 32'hAAAA_BEEF, 32'h0000_0104);
        check("t2_byteen", {28'd0, m_data_byteen}, 32'hC);
        check("t2_wdata",  m_data_wdata,           32'hBEEF_BEEF);
        check("t2_addr",   m_data_addr,            32'h0000_1004);
        offer(MARK_SH, 32'h0000_1001, 32'h1111_2222, 32'h0000_0108);
        check("t2_misalign_pulse", {31'd0, st_misalign}, 32'd1);
        check("t2_head_kept",      m_data_addr,          32'h0000_1004);
        @(posedge clk);
        #2;
        check("t2_misalign_end", {31'd0, st_misalign}, 32'd0);
        offer(6'd0, 32'h0000_1003, 32'h3333_4444, 32'h0000_010C);
        check("t2_noop_no_pulse", {31'd0, st_misalign}, 32'd0);
        offer(MARK_SW, 32'h0000_1002, 32'h5555_6666, 32'h0000_0110);
        check("t2_sw_misalign", {31'd0, st_misalign}, 32'd1);
        m_data_gnt = 1'b1;
        wait_empty(6);
        m_data_gnt = 1'b0;

        // 3: fill with 4 sw, offers held off while full, then drain in order
        for (int i = 0; i < 4; i++) begin
            expect_write(32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111, 32'h0000_0200 + 32'(4 * i));
            offer(MARK_SW, 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h0000_0200 + 32'(4 * i));
            if (i == 2) check("t3_ready_3", {31'd0, st_ready}, 32'd1);
        end
        check("t3_full_ready", {31'd0, st_ready}, 32'd0);
        offer(MARK_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0210);
        offer(MARK_SH, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0214);
        check("t3_full_no_pulse", {31'd0, st_misalign}, 32'd0);
        check("t3_head",          m_data_addr,          32'h0000_0000);
        m_data_gnt = 1'b1;
        #1;
        check("t3_full_pop_ready", {31'd0, st_ready}, 32'd0);
        wait_empty(8);
        m_data_gnt = 1'b0;

        // 4: load hazard on word match; same-cycle store not compared
        st_valid = 1'b1; st_mark = MARK_SW; st_addr = 32'h0000_2010;
        st_data = 32'h0BAD_F00D; st_pc = 32'h0000_0300;
        ld_check = 1'b1; ld_addr = 32'h0000_2010;
        #1;
        check("t4_same_cycle", {31'd0, ld_hazard}, 32'd0);
        expect_write(32'h0000_2010, 32'h0BAD_F00D, 4'b1111, 32'h0000_0300);
        @(posedge clk);
        #1;
        st_valid = 1'b0; st_mark = 6'd0;
        ld_addr = 32'h0000_2012;
        #1;
        check("t4_hit", {31'd0, ld_hazard}, 32'd1);
        ld_addr = 32'h0000_2014;
        #1;
        check("t4_miss", {31'd0, ld_hazard}, 32'd0);
        ld_check = 1'b0; ld_addr = 32'h0000_2010;
        #1;
        check("t4_no_check", {31'd0, ld_hazard}, 32'd0);
        m_data_gnt = 1'b1;
        wait_empty(4);
        m_data_gnt = 1'b0;

        // 5: count=2 with simultaneous push+pop for 3*DEPTH cycles
        for (int i = 0; i < 2; i++) begin
            expect_write(32'h0000_4000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'b1111, 32'h0000_0400 + 32'(i));
            offer(MARK_SW, 32'h0000_4000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 32'h0000_0400 + 32'(i));
        end
        m_data_gnt = 1'b1;
        for (int i = 2; i < 14; i++) begin
            st_valid = 1'b1; st_mark = MARK_SW;
            st_addr = 32'h0000_4000 + 32'(4 * i);
            st_data = 32'hC000_0000 + 32'(i);
            st_pc   = 32'h0000_0400 + 32'(i);
            expect_write(st_addr, st_data, 4'b1111, st_pc);
            @(posedge clk);
            #1;
            if (i == 5 || i == 13) begin
                check("t5_not_empty", {31'd0, q_empty},  32'd0);
                check("t5_ready",     {31'd0, st_ready}, 32'd1);
            end
        end
        st_valid = 1'b0; st_mark = 6'd0;
        wait_empty(4);
        m_data_gnt = 1'b0;

        // 6: reset with 3 entries queued and a grant pending
        for (int i = 0; i < 3; i++) begin
            offer(MARK_SW, 32'h0000_6000 + 32'(4 * i), 32'hE000_0000 + 32'(i), 32'h0000_0600);
        end
        reset = 1'b1;
        m_data_gnt = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ld_check = 1'b1; ld_addr = 32'h0000_6000;
        #1;
        check("t6_empty",   {31'd0, q_empty},       32'd1);
        check("t6_req",     {31'd0, m_data_req},    32'd0);
        check("t6_addr",    m_data_addr,            32'd0);
        check("t6_wdata",   m_data_wdata,           32'd0);
        check("t6_byteen",  {28'd0, m_data_byteen}, 32'd0);
        check("t6_pc",      m_inst_addr,            32'd0);
        check("t6_ready",   {31'd0, st_ready},      32'd1);
        check("t6_hazard",  {31'd0, ld_hazard},     32'd0);
        repeat (4) @(posedge clk);
        #1;
        ld_check = 1'b0;
        m_data_gnt = 1'b0;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
